// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises SCLK/COPI/nCS into clk, shifts MSB-first
// R/W + address + data frames and reports each one as valid or malformed on nCS rise.
module spi_frame_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       frame_valid_o,
    output logic       frame_err_o,
    output logic       frame_rw_o,
    output logic [6:0] frame_addr_o,
    output logic [7:0] frame_data_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_sync, copi_sync, ncs_sync, settle;
    logic                    sclk_prev, ncs_prev;
    logic                    armed;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_q;

    logic sclk_s, copi_s, ncs_s, settled;
    logic sclk_rise, ncs_fall, ncs_rise;
    logic start, legal;

    function automatic logic frame_ok(input logic [CNT_W-1:0] cnt, input logic [6:0] addr);
        return (cnt == CNT_FULL) && (addr <= 7'(MAX_ADDR));
    endfunction

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign settled   = settle[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign start     = (state == IDLE) && ncs_fall && armed;
    assign legal     = frame_ok(bit_cnt, shift_q[FRAME_BITS-2 -: 7]);
    assign busy_o    = (state != IDLE);

    // pin synchronisers and edge-detect copies
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            settle    <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_i};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    // The reset value of the nCS chain is 1, so only arm once the chain holds
    // real post-reset samples; otherwise a low nCS held through reset looks like a fresh fall.
    always_ff @(posedge clk) begin
        if (rst)
            armed <= 1'b0;
        else if (settled && ncs_s)
            armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (ncs_rise) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // shift datapath and frame qualification
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            shift_q       <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            frame_rw_o    <= 1'b0;
            frame_addr_o  <= '0;
            frame_data_o  <= '0;
        end else begin
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                        if (bit_cnt != CNT_SAT)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        frame_valid_o <= 1'b1;
                        frame_rw_o    <= shift_q[FRAME_BITS-1];
                        frame_addr_o  <= shift_q[FRAME_BITS-2 -: 7];
                        frame_data_o  <= shift_q[7:0];
                    end else begin
                        frame_err_o   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: table of frames with hand-computed results plus
// idle-noise, mid-frame reset and coincident SCLK/nCS edge sequences.
module tb_spi_frame_rx;

    localparam int SYNC    = 2;
    localparam int LATENCY = SYNC + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk_i = 1'b0;
    logic       copi_i = 1'b0;
    logic       ncs_i = 1'b1;
    logic       frame_valid_o, frame_err_o, frame_rw_o, busy_o;
    logic [6:0] frame_addr_o;
    logic [7:0] frame_data_o;

    spi_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
        .frame_valid_o(frame_valid_o), .frame_err_o(frame_err_o),
        .frame_rw_o(frame_rw_o), .frame_addr_o(frame_addr_o),
        .frame_data_o(frame_data_o), .busy_o(busy_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        bit          coinc;
        bit          exp_valid;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
    } frame_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0, vcnt = 0, ecnt = 0, busy_cnt = 0, both_cnt = 0, last_strobe = -100;
    int rise_cyc = 0;

    // sample 2 time units after each active edge
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (frame_valid_o) vcnt++;
        if (frame_err_o) ecnt++;
        if (frame_valid_o || frame_err_o) last_strobe = cyc;
        if (frame_valid_o && frame_err_o) both_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int nbits, input bit coinc);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi_i = bits[i];
            wait_neg(4);
            sclk_i = 1'b1;
            if (i == 0 && coinc) begin
                ncs_i    = 1'b1;
                rise_cyc = cyc;
            end
            wait_neg(4);
            sclk_i = 1'b0;
        end
    endtask

    task automatic run_check(input frame_t f);
        int v0, e0, b0;
        v0 = vcnt; e0 = ecnt; b0 = busy_cnt;
        ncs_i = 1'b0;
        wait_neg(4);
        clock_bits(f.bits, f.nbits, f.coinc);
        if (!f.coinc) begin
            wait_neg(4);
            ncs_i    = 1'b1;
            rise_cyc = cyc;
        end
        wait_neg(8);
        chk("valid_count", vcnt - v0, int'(f.exp_valid));
        chk("err_count", ecnt - e0, int'(!f.exp_valid));
        chk("strobe_latency", last_strobe - rise_cyc, LATENCY);
        chk("rw", int'(frame_rw_o), int'(f.rw));
        chk("addr", int'(frame_addr_o), int'(f.addr));
        chk("data", int'(frame_data_o), int'(f.data));
        chk("busy_seen", int'(busy_cnt - b0 > 0), 1);
    endtask

    frame_t vec[7];
    frame_t f;
    int v0, e0, b0;

    initial begin
        vec[0] = '{32'h0000_80AA, 16, 1'b0, 1'b1, 1'b1, 7'h00, 8'hAA};
        vec[1] = '{32'h0000_84F0, 16, 1'b0, 1'b1, 1'b1, 7'h04, 8'hF0};
        vec[2] = '{32'h0000_8533, 16, 1'b0, 1'b0, 1'b1, 7'h04, 8'hF0};
        vec[3] = '{32'h0000_7FFF, 15, 1'b0, 1'b0, 1'b1, 7'h04, 8'hF0};
        vec[4] = '{32'h0001_80AA, 17, 1'b0, 1'b0, 1'b1, 7'h04, 8'hF0};
        vec[5] = '{32'h0000_0255, 16, 1'b0, 1'b1, 1'b0, 7'h02, 8'h55};
        vec[6] = '{32'h0000_8303, 16, 1'b1, 1'b1, 1'b1, 7'h03, 8'h03};

        @(negedge clk);
        rst = 1'b1;
        wait_neg(3);
        chk("reset_outputs", int'({frame_valid_o, frame_err_o, frame_rw_o,
                                   frame_addr_o, frame_data_o, busy_o}), 0);
        rst = 1'b0;
        wait_neg(8);

        for (int i = 0; i < 7; i++)
            run_check(vec[i]);

        // SCLK and COPI activity with nCS high
        v0 = vcnt; e0 = ecnt; b0 = busy_cnt;
        for (int i = 0; i < 20; i++) begin
            copi_i = 1'($urandom_range(0, 1));
            sclk_i = ~sclk_i;
            wait_neg(4);
        end
        sclk_i = 1'b0;
        wait_neg(8);
        chk("noise_valid", vcnt - v0, 0);
        chk("noise_err", ecnt - e0, 0);
        chk("noise_busy", busy_cnt - b0, 0);

        // reset in the middle of a frame, nCS kept low afterwards
        v0 = vcnt; e0 = ecnt;
        ncs_i = 1'b0;
        wait_neg(4);
        clock_bits(32'h0000_0081, 8, 1'b0);
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        b0 = busy_cnt;
        clock_bits(32'h0000_00C3, 8, 1'b0);
        wait_neg(4);
        ncs_i = 1'b1;
        wait_neg(8);
        chk("midreset_valid", vcnt - v0, 0);
        chk("midreset_err", ecnt - e0, 0);
        chk("midreset_busy", busy_cnt - b0, 0);
        chk("midreset_addr", int'(frame_addr_o), 0);
        f = '{32'h0000_8101, 16, 1'b0, 1'b1, 1'b1, 7'h01, 8'h01};
        run_check(f);

        chk("valid_and_err_together", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
